// File: rtl/iod_multilane_icb_align_if.sv
// Handshake/control bundle between the alignment trainer and the IOD/ICB lanes.
// master = lane/controller side driving requests and DEM flags; slave = the trainer.
interface iod_multilane_icb_align_if #(
  parameter int NUM_LANES = 4,
  parameter int TAP_W     = 8
);
  logic                       TRAIN_START;
  logic                       ALGN_HOLD;
  logic                       ALGN_RSTRT;
  logic [NUM_LANES-1:0]       IOD_EARLY;
  logic [NUM_LANES-1:0]       IOD_LATE;
  logic [NUM_LANES-1:0]       IOD_OOR;
  logic [NUM_LANES-1:0]       ICB_LOAD;
  logic [NUM_LANES-1:0]       ICB_MOV;
  logic [NUM_LANES-1:0]       ICB_DIR;
  logic [NUM_LANES-1:0]       ICB_CLR_FLGS;
  logic [NUM_LANES*TAP_W-1:0] ICB_TAPDLY;
  logic                       TRAIN_DONE;
  logic [NUM_LANES-1:0]       ALGN_ERR;
  logic                       ALGN_PAUSE;

  modport master (
    output TRAIN_START, ALGN_HOLD, ALGN_RSTRT, IOD_EARLY, IOD_LATE, IOD_OOR,
    input  ICB_LOAD, ICB_MOV, ICB_DIR, ICB_CLR_FLGS, ICB_TAPDLY,
           TRAIN_DONE, ALGN_ERR, ALGN_PAUSE
  );

  modport slave (
    input  TRAIN_START, ALGN_HOLD, ALGN_RSTRT, IOD_EARLY, IOD_LATE, IOD_OOR,
    output ICB_LOAD, ICB_MOV, ICB_DIR, ICB_CLR_FLGS, ICB_TAPDLY,
           TRAIN_DONE, ALGN_ERR, ALGN_PAUSE
  );
endinterface

// File: rtl/iod_multilane_icb_align.sv
// Per-lane ICB tap sweep: find the first contiguous valid window, return to its centre.
// Define ICB_ALIGN_OFFSET_EN to add the signed ICB_BCLKPHS_OFFSET trim on the centre tap.
module iod_multilane_icb_align #(
  parameter int NUM_LANES = 4,
  parameter int TAP_W     = 8,
  parameter int WAIT_W    = 3
) (
  input  logic                     SCLK,
  input  logic                     RESETN,
`ifdef ICB_ALIGN_OFFSET_EN
  input  logic [TAP_W-1:0]         ICB_BCLKPHS_OFFSET,
`endif
  iod_multilane_icb_align_if.slave bus
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [3:0] {
    IDLE, CLR, LOAD, SETTLE, SAMPLE, STEP, RETURN, NEXT, DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [TAP_W-1:0]           first_q, first_d;
  logic [TAP_W-1:0]           last_q, last_d;
  logic [TAP_W-1:0]           target_q, target_d;
  logic [WAIT_W-1:0]          cnt_q, cnt_d;
  logic                       found_q, found_d;
  logic                       phase_q, phase_d;
  logic [NUM_LANES-1:0]       load_q, load_d;
  logic [NUM_LANES-1:0]       mov_q, mov_d;
  logic [NUM_LANES-1:0]       dir_q, dir_d;
  logic [NUM_LANES-1:0]       clr_q, clr_d;
  logic [NUM_LANES-1:0]       err_q, err_d;
  logic [NUM_LANES*TAP_W-1:0] tapdly_q, tapdly_d;
  logic                       done_q, done_d;
  logic                       pause_q, pause_d;

  logic                       valid, sweep_end, found_n;
  logic [TAP_W-1:0]           first_n, last_n, centre, tgt;
  logic [TAP_W:0]             sum;
`ifdef ICB_ALIGN_OFFSET_EN
  logic signed [TAP_W+1:0]    adj;
`endif

  // Window tracking for the sample being taken this cycle on the active lane.
  always_comb begin
    valid   = !bus.IOD_EARLY[lane_q] && !bus.IOD_LATE[lane_q];
    first_n = first_q;
    last_n  = last_q;
    found_n = found_q;
    if (valid) begin
      if (!found_q) first_n = tap_q;
      last_n  = tap_q;
      found_n = 1'b1;
    end
    sweep_end = (found_q && !valid) || bus.IOD_OOR[lane_q] || (tap_q == '1);
    sum       = {1'b0, first_n} + {1'b0, last_n};
    centre    = found_n ? TAP_W'(sum >> 1) : '0;
`ifdef ICB_ALIGN_OFFSET_EN
    adj = $signed({2'b00, centre}) +
          $signed({{2{ICB_BCLKPHS_OFFSET[TAP_W-1]}}, ICB_BCLKPHS_OFFSET});
    // Capped at last so the return phase only ever moves backwards.
    if (!found_n || adj < 0)                   tgt = '0;
    else if (adj > $signed({2'b00, last_n}))   tgt = last_n;
    else                                       tgt = adj[TAP_W-1:0];
`else
    tgt = centre;
`endif
  end

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    tap_d    = tap_q;
    first_d  = first_q;
    last_d   = last_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    phase_d  = phase_q;
    err_d    = err_q;
    tapdly_d = tapdly_q;
    load_d   = '0;
    mov_d    = '0;
    dir_d    = '1;
    clr_d    = '0;

    if (!bus.ALGN_HOLD) begin
      case (state_q)
        IDLE:   if (bus.TRAIN_START) begin
                  state_d = CLR;
                  lane_d  = '0;
                end
        CLR:    state_d = LOAD;
        LOAD:   begin
                  state_d = SETTLE;
                  tap_d   = '0;
                  first_d = '0;
                  last_d  = '0;
                  found_d = 1'b0;
                  cnt_d   = '0;
                end
        SETTLE: if (cnt_q == '1) begin
                  state_d = SAMPLE;
                  cnt_d   = '0;
                end else begin
                  cnt_d = cnt_q + 1'b1;
                end
        SAMPLE: begin
                  first_d = first_n;
                  last_d  = last_n;
                  found_d = found_n;
                  if (sweep_end) begin
                    state_d        = RETURN;
                    target_d       = tgt;
                    err_d[lane_q]  = !found_n;
                    phase_d        = 1'b0;
                  end else begin
                    state_d = STEP;
                  end
                end
        STEP:   begin
                  state_d = SETTLE;
                  tap_d   = tap_q + 1'b1;
                  cnt_d   = '0;
                end
        // Move issued on phase 0 appears registered on phase 1, giving one pulse per 2 cycles.
        RETURN: if (tap_q == target_q) begin
                  tapdly_d[lane_q*TAP_W +: TAP_W] = target_q;
                  state_d = NEXT;
                end else if (!phase_q) begin
                  mov_d[lane_q] = 1'b1;
                  dir_d[lane_q] = 1'b0;
                  tap_d         = tap_q - 1'b1;
                  phase_d       = 1'b1;
                end else begin
                  phase_d = 1'b0;
                end
        NEXT:   if (lane_q == LAST_LANE) begin
                  state_d = DONE;
                end else begin
                  lane_d  = lane_q + 1'b1;
                  state_d = CLR;
                end
        DONE:   if (bus.ALGN_RSTRT) begin
                  state_d = IDLE;
                  err_d   = '0;
                end
        default: state_d = IDLE;
      endcase

      // Pulses are decoded from the next state so they register in step with it.
      if (state_d == CLR || state_d == STEP) clr_d[lane_d] = 1'b1;
      if (state_d == LOAD)                   load_d[lane_d] = 1'b1;
      if (state_d == STEP)                   mov_d[lane_d]  = 1'b1;
    end

    done_d  = (state_d == DONE);
    pause_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      tap_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      phase_q  <= 1'b0;
      load_q   <= '0;
      mov_q    <= '0;
      dir_q    <= '1;
      clr_q    <= '0;
      err_q    <= '0;
      tapdly_q <= '0;
      done_q   <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      tap_q    <= tap_d;
      first_q  <= first_d;
      last_q   <= last_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      phase_q  <= phase_d;
      load_q   <= load_d;
      mov_q    <= mov_d;
      dir_q    <= dir_d;
      clr_q    <= clr_d;
      err_q    <= err_d;
      tapdly_q <= tapdly_d;
      done_q   <= done_d;
      pause_q  <= pause_d;
    end
  end

  assign bus.ICB_LOAD     = load_q;
  assign bus.ICB_MOV      = mov_q;
  assign bus.ICB_DIR      = dir_q;
  assign bus.ICB_CLR_FLGS = clr_q;
  assign bus.ICB_TAPDLY   = tapdly_q;
  assign bus.TRAIN_DONE   = done_q;
  assign bus.ALGN_ERR     = err_q;
  assign bus.ALGN_PAUSE   = pause_q;
endmodule
